cbl_psr: RTL and testbench
==========================

# cbl_psr

Control Branch Logic with Processor Status Register for the microprogrammed control unit. Every cycle it evaluates the COND field of the current microinstruction against the stored condition codes (N, Z, V, C) and IR bit 13, and drives the 2-bit `Tipo` select that the control-store address register directly downstream uses to choose the next microaddress (00 Next, 01 Jump, 10 Decode). It owns the PSR: it latches the ALU flags when a condition-code-setting ALU operation executes, and it accepts explicit PSR loads from the datapath.

## Interface
- `DATAWIDTH_CBL`, 2, width of the Tipo select.
- `DATAWIDTH_COND`, 3, width of the microword COND field.
- `DATAWIDTH_ALUOP`, 4, width of the microword ALU function field.
- `DATAWIDTH_FLAGS`, 4, PSR width, ordered {N,Z,V,C} from MSB to LSB.

Ports:
- `CBLPSR_CLOCK_50`, in, 1, the single system clock; all state updates on its rising edge.
- `CBLPSR_ResetInHigh_In`, in, 1, reset, synchronous and active-high.
- `CBLPSR_Cond_InBus`, in, 3, COND field of the current microinstruction.
- `CBLPSR_ALUOp_InBus`, in, 4, ALU function of the current microinstruction.
- `CBLPSR_ALUFlags_InBus`, in, 4, {N,Z,V,C} produced by the ALU this cycle.
- `CBLPSR_IR13_In`, in, 1, instruction register bit 13.
- `CBLPSR_PSRLoad_In`, in, 1, load the PSR from the data input.
- `CBLPSR_PSRData_InBus`, in, 4, PSR load value.
- `CBLPSR_Tipo_OutBus`, out, 2, next-address select, combinational.
- `CBLPSR_PSR_OutBus`, out, 4, registered PSR.
- `CBLPSR_JumpTaken_Out`, out, 1, registered; high if the previous cycle's Tipo was 01.

## Operation
- COND decode to Tipo:
  - 000 → 00.
  - 001 → 01 if N, else 00.
  - 010 → 01 if Z, else 00.
  - 011 → 01 if V, else 00.
  - 100 → 01 if C, else 00.
  - 101 → 01 if IR13, else 00.
  - 110 → 01 unconditionally.
  - 111 → 10 (Decode).
- Tipo value 11 is never driven.
- Condition-code-setting ALU ops: 0000 ANDCC, 0001 ORCC, 0010 NORCC, 0011 ADDCC. Any other ALU op leaves the PSR unchanged.
- PSR next-state priority:
  1. Reset → 4'b0000.
  2. `PSRLoad` → `PSRData`.
  3. CC-setting op → `ALUFlags`.
  4. Otherwise hold.
- `JumpTaken` registers `(Tipo == 01)` every cycle.
- Flags used for the branch decision (default build): the registered PSR, i.e. the condition codes as they stood before this microinstruction.

## Timing
- Tipo is combinational from COND, PSR and IR13 within the same cycle. It is sampled by the downstream address register on the same edge that updates the PSR.
- A PSR update lands one edge after the CC-setting microinstruction. A branch in the following microinstruction sees the new value.
- A load and a CC-setting op in the same cycle: the load wins, and the ALU flags are discarded.
- Reset is synchronous:
  - At the first rising edge with reset high, PSR = 0000 and `JumpTaken` = 0.
  - While reset is held, Tipo is still combinational, with the PSR at 0.
  - Reset asserted mid-stream discards any pending flag update from that cycle.
- Reset values: `PSR_OutBus` = 4'b0000, `JumpTaken_Out` = 0. `Tipo_OutBus` is 00 when COND = 000.

## Configuration
- Macro: `CBLPSR_FLAG_BYPASS_EN`.
- Defined: when the current ALU op is CC-setting and `PSRLoad` is low, the branch decision for COND 001–100 uses `ALUFlags_InBus` directly. This lets one microinstruction compute and branch on the result. The PSR register update itself is unchanged.
- Undefined: the branch decision always uses the registered PSR.

## Structure
- Shared package (`cbl_pkg`):
  - COND codes (`COND_NEXT` … `COND_DECODE`).
  - Tipo codes (`TIPO_NEXT` = 00, `TIPO_JUMP` = 01, `TIPO_DECODE` = 10).
  - CC-setting ALU op codes.
  - Flag bit indices (`FLAG_N` = 3 … `FLAG_C` = 0).
- One natural sub-module: `cbl_psr_reg`, holding the 4-bit PSR with the priority load/update mux. The branch decode stays in the top level.

## Test plan
- Reset: hold reset 2 cycles with COND = 110 → PSR = 0000, `JumpTaken` = 0, Tipo = 01. Release reset → next cycle `JumpTaken` = 1.
- Flag latch: ALUOp = 0011, ALUFlags = 0100 for one cycle, then COND = 010 → PSR = 0100, Tipo = 01. With COND = 001 → Tipo = 00.
- Non-CC op: ALUOp = 0101, ALUFlags = 1111 → PSR holds the previous value 0100.
- Load priority: `PSRLoad` = 1, PSRData = 0001, ALUOp = 0011, ALUFlags = 1000 → PSR = 0001. Then COND = 100 → Tipo = 01.
- Decode/IR13: COND = 111 → Tipo = 10 for any PSR. COND = 101 with IR13 = 1 → 01, with IR13 = 0 → 00.
- Bypass: PSR = 0000, ALUOp = 0000, ALUFlags = 0010, COND = 011.
  - With `CBLPSR_FLAG_BYPASS_EN` defined → Tipo = 01 in the same cycle.
  - Without it → Tipo = 00.
  - Either build → next cycle PSR = 0010.

Source files
------------

// File: rtl/cbl_pkg.sv
// Shared codes for the control branch logic: COND field values, Tipo selects,
// condition-code-setting ALU ops and PSR flag bit positions.
package cbl_pkg;

    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    localparam logic [1:0] TIPO_NEXT   = 2'b00;
    localparam logic [1:0] TIPO_JUMP   = 2'b01;
    localparam logic [1:0] TIPO_DECODE = 2'b10;

    localparam logic [3:0] ALUOP_ANDCC = 4'b0000;
    localparam logic [3:0] ALUOP_ORCC  = 4'b0001;
    localparam logic [3:0] ALUOP_NORCC = 4'b0010;
    localparam logic [3:0] ALUOP_ADDCC = 4'b0011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic isCcOp(input logic [3:0] aluOp);
        return (aluOp == ALUOP_ANDCC) || (aluOp == ALUOP_ORCC) ||
               (aluOp == ALUOP_NORCC) || (aluOp == ALUOP_ADDCC);
    endfunction

endpackage

// File: rtl/cbl_psr_reg.sv
// Processor Status Register {N,Z,V,C}: reset, then explicit load, then ALU
// flag capture on a condition-code-setting op, otherwise hold.
module cbl_psr_reg #(
    parameter int DATAWIDTH_FLAGS = 4
) (
    input  logic                       PSRREG_CLOCK_50,
    input  logic                       PSRREG_ResetInHigh_In,
    input  logic                       PSRREG_Load_In,
    input  logic [DATAWIDTH_FLAGS-1:0] PSRREG_Data_InBus,
    input  logic                       PSRREG_CcOp_In,
    input  logic [DATAWIDTH_FLAGS-1:0] PSRREG_Flags_InBus,
    output logic [DATAWIDTH_FLAGS-1:0] PSRREG_PSR_OutBus
);

    logic [DATAWIDTH_FLAGS-1:0] psrReg_p1;

    // stage p1: PSR register, load beats flag capture
    always_ff @(posedge PSRREG_CLOCK_50) begin
        if (PSRREG_ResetInHigh_In) begin
            psrReg_p1 <= '0;
        end else if (PSRREG_Load_In) begin
            psrReg_p1 <= PSRREG_Data_InBus;
        end else if (PSRREG_CcOp_In) begin
            psrReg_p1 <= PSRREG_Flags_InBus;
        end
    end

    assign PSRREG_PSR_OutBus = psrReg_p1;

endmodule

// File: rtl/cbl_psr.sv
// Control branch logic with PSR: decodes COND against flags/IR13 into Tipo.
// Optional macro CBLPSR_FLAG_BYPASS_EN lets a CC-setting op branch on its own flags.
module cbl_psr
    import cbl_pkg::*;
#(
    parameter int DATAWIDTH_CBL   = 2,
    parameter int DATAWIDTH_COND  = 3,
    parameter int DATAWIDTH_ALUOP = 4,
    parameter int DATAWIDTH_FLAGS = 4
) (
    input  logic                       CBLPSR_CLOCK_50,
    input  logic                       CBLPSR_ResetInHigh_In,
    input  logic [DATAWIDTH_COND-1:0]  CBLPSR_Cond_InBus,
    input  logic [DATAWIDTH_ALUOP-1:0] CBLPSR_ALUOp_InBus,
    input  logic [DATAWIDTH_FLAGS-1:0] CBLPSR_ALUFlags_InBus,
    input  logic                       CBLPSR_IR13_In,
    input  logic                       CBLPSR_PSRLoad_In,
    input  logic [DATAWIDTH_FLAGS-1:0] CBLPSR_PSRData_InBus,
    output logic [DATAWIDTH_CBL-1:0]   CBLPSR_Tipo_OutBus,
    output logic [DATAWIDTH_FLAGS-1:0] CBLPSR_PSR_OutBus,
    output logic                       CBLPSR_JumpTaken_Out
);

    logic                       ccOp_p0;
    logic [DATAWIDTH_FLAGS-1:0] psr_p1;
    logic [DATAWIDTH_FLAGS-1:0] branchFlags_p0;
    logic [DATAWIDTH_CBL-1:0]   tipo_p0;
    logic                       jumpTaken_p1;

    assign ccOp_p0 = isCcOp(CBLPSR_ALUOp_InBus);

    cbl_psr_reg #(
        .DATAWIDTH_FLAGS(DATAWIDTH_FLAGS)
    ) psrReg (
        .PSRREG_CLOCK_50      (CBLPSR_CLOCK_50),
        .PSRREG_ResetInHigh_In(CBLPSR_ResetInHigh_In),
        .PSRREG_Load_In       (CBLPSR_PSRLoad_In),
        .PSRREG_Data_InBus    (CBLPSR_PSRData_InBus),
        .PSRREG_CcOp_In       (ccOp_p0),
        .PSRREG_Flags_InBus   (CBLPSR_ALUFlags_InBus),
        .PSRREG_PSR_OutBus    (psr_p1)
    );

`ifdef CBLPSR_FLAG_BYPASS_EN
    // A load in the same cycle overrides the flags, so the bypass only applies without one.
    assign branchFlags_p0 = (ccOp_p0 && !CBLPSR_PSRLoad_In) ? CBLPSR_ALUFlags_InBus : psr_p1;
`else
    assign branchFlags_p0 = psr_p1;
`endif

    // stage p0: combinational branch decode, sampled downstream on the next edge
    always_comb begin
        tipo_p0 = TIPO_NEXT;
        case (CBLPSR_Cond_InBus)
            COND_NEXT:   tipo_p0 = TIPO_NEXT;
            COND_N:      tipo_p0 = branchFlags_p0[FLAG_N] ? TIPO_JUMP : TIPO_NEXT;
            COND_Z:      tipo_p0 = branchFlags_p0[FLAG_Z] ? TIPO_JUMP : TIPO_NEXT;
            COND_V:      tipo_p0 = branchFlags_p0[FLAG_V] ? TIPO_JUMP : TIPO_NEXT;
            COND_C:      tipo_p0 = branchFlags_p0[FLAG_C] ? TIPO_JUMP : TIPO_NEXT;
            COND_IR13:   tipo_p0 = CBLPSR_IR13_In ? TIPO_JUMP : TIPO_NEXT;
            COND_JUMP:   tipo_p0 = TIPO_JUMP;
            COND_DECODE: tipo_p0 = TIPO_DECODE;
            default:     tipo_p0 = TIPO_NEXT;
        endcase
    end

    // stage p1: remember whether the previous cycle jumped
    always_ff @(posedge CBLPSR_CLOCK_50) begin
        if (CBLPSR_ResetInHigh_In) begin
            jumpTaken_p1 <= 1'b0;
        end else begin
            jumpTaken_p1 <= (tipo_p0 == TIPO_JUMP);
        end
    end

    assign CBLPSR_Tipo_OutBus   = tipo_p0;
    assign CBLPSR_PSR_OutBus    = psr_p1;
    assign CBLPSR_JumpTaken_Out = jumpTaken_p1;

endmodule

// File: tb/tb_cbl_psr.sv
// Vector-table bench for cbl_psr: Tipo checked before each edge, PSR and
// JumpTaken checked after it through an expectation queue.
module tb_cbl_psr;

`ifdef CBLPSR_FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [2:0] cond;
        logic [3:0] aluOp;
        logic [3:0] flags;
        logic       ir13;
        logic       load;
        logic [3:0] data;
        logic [1:0] expTipo;
        logic [3:0] expPsr;
        logic       expJt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] psr;
        logic       jt;
    } post_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cond;
    logic [3:0] aluOp;
    logic [3:0] aluFlags;
    logic       ir13;
    logic       psrLoad;
    logic [3:0] psrData;
    logic [1:0] tipo;
    logic [3:0] psr;
    logic       jumpTaken;

    int total = 0;
    int bad   = 0;

    vec_t  vecs[$];
    post_t sb[$];

    always #5 clk = ~clk;

    cbl_psr dut (
        .CBLPSR_CLOCK_50      (clk),
        .CBLPSR_ResetInHigh_In(rst),
        .CBLPSR_Cond_InBus    (cond),
        .CBLPSR_ALUOp_InBus   (aluOp),
        .CBLPSR_ALUFlags_InBus(aluFlags),
        .CBLPSR_IR13_In       (ir13),
        .CBLPSR_PSRLoad_In    (psrLoad),
        .CBLPSR_PSRData_InBus (psrData),
        .CBLPSR_Tipo_OutBus   (tipo),
        .CBLPSR_PSR_OutBus    (psr),
        .CBLPSR_JumpTaken_Out (jumpTaken)
    );

    function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [3:0] op,
                                input logic [3:0] f, input logic i, input logic ld,
                                input logic [3:0] d, input logic [1:0] t,
                                input logic [3:0] p, input logic j);
        vec_t v;
        v.rst = r; v.cond = c; v.aluOp = op; v.flags = f; v.ir13 = i;
        v.load = ld; v.data = d; v.expTipo = t; v.expPsr = p; v.expJt = j;
        return v;
    endfunction

    initial begin
        post_t got;
        rst = 1'b1; cond = 3'b000; aluOp = 4'b0101; aluFlags = 4'b0000;
        ir13 = 1'b0; psrLoad = 1'b0; psrData = 4'b0000;

        //          rst  cond    aluOp    flags    ir13 ld   data     tipo   psr      jt
        vecs.push_back(mk(1, 3'b110, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b01, 4'b0000, 0)); // reset cycle 1
        vecs.push_back(mk(1, 3'b110, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b01, 4'b0000, 0)); // reset cycle 2
        vecs.push_back(mk(0, 3'b110, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b01, 4'b0000, 1)); // release
        vecs.push_back(mk(0, 3'b000, 4'b0011, 4'b0100, 0, 0, 4'b0000, 2'b00, 4'b0100, 0)); // ADDCC latch
        vecs.push_back(mk(0, 3'b010, 4'b0101, 4'b1111, 0, 0, 4'b0000, 2'b01, 4'b0100, 1)); // Z branch, non-CC hold
        vecs.push_back(mk(0, 3'b001, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b00, 4'b0100, 0)); // N clear
        vecs.push_back(mk(0, 3'b000, 4'b0011, 4'b1000, 0, 1, 4'b0001, 2'b00, 4'b0001, 0)); // load beats ADDCC
        vecs.push_back(mk(0, 3'b100, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b01, 4'b0001, 1)); // C branch
        vecs.push_back(mk(0, 3'b111, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b10, 4'b0001, 0)); // decode
        vecs.push_back(mk(0, 3'b101, 4'b0101, 4'b0000, 1, 0, 4'b0000, 2'b01, 4'b0001, 1)); // IR13=1
        vecs.push_back(mk(0, 3'b101, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b00, 4'b0001, 0)); // IR13=0
        vecs.push_back(mk(0, 3'b011, 4'b0101, 4'b0000, 0, 1, 4'b0000, 2'b00, 4'b0000, 0)); // load zero
        vecs.push_back(mk(0, 3'b011, 4'b0000, 4'b0010, 0, 0, 4'b0000,
                          BYP ? 2'b01 : 2'b00, 4'b0010, BYP));                          // bypass case
        vecs.push_back(mk(0, 3'b011, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b01, 4'b0010, 1)); // V now set
        vecs.push_back(mk(0, 3'b111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 2'b10, 4'b0010, 0)); // decode, other PSR
        vecs.push_back(mk(1, 3'b000, 4'b0011, 4'b1111, 0, 0, 4'b0000, 2'b00, 4'b0000, 0)); // mid reset drops flags
        vecs.push_back(mk(0, 3'b100, 4'b0101, 4'b0000, 0, 0, 4'b0000, 2'b00, 4'b0000, 0)); // C clear
        vecs.push_back(mk(0, 3'b000, 4'b0001, 4'b1001, 0, 0, 4'b0000, 2'b00, 4'b1001, 0)); // ORCC latch
        vecs.push_back(mk(0, 3'b110, 4'b0010, 4'b0110, 0, 0, 4'b0000, 2'b01, 4'b0110, 1)); // NORCC latch
        vecs.push_back(mk(0, 3'b010, 4'b0100, 4'b1111, 0, 0, 4'b0000, 2'b01, 4'b0110, 1)); // op 0100 holds

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            cond     = vecs[i].cond;
            aluOp    = vecs[i].aluOp;
            aluFlags = vecs[i].flags;
            ir13     = vecs[i].ir13;
            psrLoad  = vecs[i].load;
            psrData  = vecs[i].data;
            sb.push_back('{idx: i, psr: vecs[i].expPsr, jt: vecs[i].expJt});
            #4;
            total++;
            if (tipo !== vecs[i].expTipo) begin
                bad++;
                $display("FAIL tipo vec%0d: got %b want %b", i, tipo, vecs[i].expTipo);
            end
            @(posedge clk);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard vec%0d: queue empty", i);
            end else begin
                got = sb.pop_front();
                if (psr !== got.psr) begin
                    bad++;
                    $display("FAIL psr vec%0d: got %b want %b", got.idx, psr, got.psr);
                end
                total++;
                if (jumpTaken !== got.jt) begin
                    bad++;
                    $display("FAIL jumpTaken vec%0d: got %b want %b", got.idx, jumpTaken, got.jt);
                end
            end
        end

        // Decode must ignore the PSR entirely: sweep every loaded value.
        for (int p = 0; p < 16; p++) begin
            rst = 1'b0; cond = 3'b000; aluOp = 4'b0101; psrLoad = 1'b1; psrData = p[3:0];
            @(posedge clk);
            #1;
            psrLoad = 1'b0; cond = 3'b111;
            #1;
            total++;
            if (tipo !== 2'b10 || psr !== p[3:0]) begin
                bad++;
                $display("FAIL decode sweep psr=%b: got tipo %b psr %b want tipo 10", p[3:0], tipo, psr);
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
